// File: rtl/program_loader.sv
// program_loader: byte-serial program image loader for the instruction memory.
// Holds the CPU in reset while a length/data/checksum image is streamed in.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Start,
    input  logic [7:0]            i_Byte,
    input  logic                  i_ByteValid,
    output logic                  o_ByteReady,
    output logic                  o_WE,
    output logic [ADDR_WIDTH-1:0] o_WAddr,
    output logic [15:0]           o_WData,
    output logic                  o_CPUHold,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic [ADDR_WIDTH:0]   o_WordCount
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] C_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_WIDTH:0] r_count;
    logic [ADDR_WIDTH:0] r_n;
    logic [7:0]          r_hi;
    logic [7:0]          r_lo;
    logic [7:0]          r_sum;
    logic [TW-1:0]       r_timer;

    logic                w_wait;
    logic                w_xfer;
    logic                w_tmo;
    logic                w_idle;
    logic [ADDR_WIDTH:0] w_count_inc;

    assign w_wait = (r_state == S_LEN) || (r_state == S_HI) ||
                    (r_state == S_LO)  || (r_state == S_CHK);
    assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE) ||
                    (r_state == S_ERR);
    assign w_xfer = w_wait && i_ByteValid;
    // Timeout fires on the idle cycle that would bring the count to TIMEOUT
    assign w_tmo  = w_wait && !i_ByteValid && (r_timer == T_LAST);
    assign w_count_inc = r_count + C_ONE;

    // State register
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_Start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_tmo) w_next = S_ERR;
                else if (w_xfer) w_next = S_HI;
            end
            S_HI: begin
                if (w_tmo) w_next = S_ERR;
                else if (w_xfer) w_next = S_LO;
            end
            S_LO: begin
                if (w_tmo) w_next = S_ERR;
                else if (w_xfer) w_next = S_WR;
            end
            S_WR: begin
                w_next = (w_count_inc == r_n) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (w_tmo) w_next = S_ERR;
                else if (w_xfer) w_next = (i_Byte == r_sum) ? S_DONE : S_ERR;
            end
        endcase
    end

    // Datapath: byte capture, checksum, word count and idle timer
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            r_count <= '0;
            r_n     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_sum   <= '0;
            r_timer <= '0;
        end else begin
            if (w_xfer || !w_wait) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + T_ONE;
            end
            if (w_idle && i_Start) begin
                r_count <= '0;
                r_sum   <= '0;
            end
            if (w_xfer && r_state == S_LEN) begin
                r_n <= (ADDR_WIDTH + 1)'(i_Byte) + C_ONE;
            end
            if (w_xfer && r_state == S_HI) begin
                r_hi  <= i_Byte;
                r_sum <= r_sum + i_Byte;
            end
            if (w_xfer && r_state == S_LO) begin
                r_lo  <= i_Byte;
                r_sum <= r_sum + i_Byte;
            end
            if (r_state == S_WR) begin
                r_count <= w_count_inc;
            end
        end
    end

    assign o_ByteReady = w_wait;
    assign o_WE        = (r_state == S_WR);
    assign o_Busy      = w_wait || (r_state == S_WR);
    assign o_Done      = (r_state == S_DONE);
    assign o_Error     = (r_state == S_ERR);
    // A failed image keeps the core parked in reset
    assign o_CPUHold   = o_Busy || (r_state == S_ERR);
    assign o_WAddr     = r_count[ADDR_WIDTH-1:0];
    assign o_WData     = {r_hi, r_lo};
    assign o_WordCount = r_count;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized image loads against
// a queue-based model of expected memory writes and checksum outcome.
module tb_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] byte_in;
    logic       valid;
    logic       rdy;
    logic       we;
    logic [7:0] waddr;
    logic [15:0] wdata;
    logic       hold;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] wcount;

    int checks = 0;
    int errors = 0;
    int consumed = 0;
    logic [23:0] wq[$];
    logic [15:0] words[256];

    program_loader #(
        .ADDR_WIDTH(8),
        .TIMEOUT(20)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst_n),
        .i_Start(start),
        .i_Byte(byte_in),
        .i_ByteValid(valid),
        .o_ByteReady(rdy),
        .o_WE(we),
        .o_WAddr(waddr),
        .o_WData(wdata),
        .o_CPUHold(hold),
        .o_Busy(busy),
        .o_Done(done),
        .o_Error(err),
        .o_WordCount(wcount)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid && rdy) consumed++;
        if (we) begin
            wq.push_back({waddr, wdata});
            check("ready_low_in_wr", 32'(rdy), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit seen;
        int n;
        valid = 1'b0;
        repeat (gap) tick();
        byte_in = b;
        valid = 1'b1;
        n = 0;
        seen = 1'b0;
        do begin
            @(negedge clk);
            seen = rdy;
            tick();
            n++;
        end while (!seen && n < 100);
        valid = 1'b0;
        if (!seen) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] image_sum(input int n);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < n; i++) begin
            s = s + words[i][15:8] + words[i][7:0];
        end
        return s;
    endfunction

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || err) && n < 3000) begin
            tick();
            n++;
        end
        check("load_end_timeout", 32'(n < 3000), 32'd1);
    endtask

    task automatic load(input int n, input logic [7:0] c,
                        input int maxgap, input bit lat);
        pulse_start();
        send_byte(8'(n - 1), $urandom_range(maxgap, 0));
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], $urandom_range(maxgap, 0));
            send_byte(words[i][7:0], $urandom_range(maxgap, 0));
            if (lat && i == 0) begin
                check("first_we_latency", 32'(we), 32'd1);
                check("first_we_addr", 32'(waddr), 32'd0);
            end
        end
        send_byte(c, $urandom_range(maxgap, 0));
        wait_end();
    endtask

    task automatic verify(input string tag, input int base, input int n);
        check({tag, "_nwrites"}, 32'(wq.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < wq.size(); i++) begin
            check({tag, "_write"}, 32'(wq[base + i]), {8'd0, 8'(i), words[i]});
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_rdy"}, 32'(rdy), 32'd0);
        check({tag, "_waddr"}, 32'(waddr), 32'd0);
        check({tag, "_wdata"}, 32'(wdata), 32'd0);
        check({tag, "_hold"}, 32'(hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(wcount), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_basic();
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        words[2] = 16'h0F0F;
    endtask

    initial begin
        int base;
        int c0;
        int n;
        bit bad;
        logic [7:0] c;
        start = 1'b0;
        valid = 1'b0;
        byte_in = 8'd0;
        do_reset();
        check_idle("reset");

        set_basic();
        base = wq.size();
        c0 = consumed;
        load(3, image_sum(3), 0, 1'b1);
        verify("basic", base, 3);
        check("basic_done", 32'(done), 32'd1);
        check("basic_err", 32'(err), 32'd0);
        check("basic_hold", 32'(hold), 32'd0);
        check("basic_count", 32'(wcount), 32'd3);
        check("basic_bytes", 32'(consumed - c0), 32'd8);

        base = wq.size();
        load(3, 8'h00, 0, 1'b0);
        verify("badsum", base, 3);
        check("badsum_err", 32'(err), 32'd1);
        check("badsum_done", 32'(done), 32'd0);
        check("badsum_hold", 32'(hold), 32'd1);
        check("badsum_count", 32'(wcount), 32'd3);
        pulse_start();
        check("restart_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        do_reset();

        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(8, 1);
            for (int i = 0; i < n; i++) words[i] = 16'($urandom);
            bad = 1'($urandom_range(1, 0));
            c = image_sum(n);
            if (bad) c = c + 8'($urandom_range(255, 1));
            base = wq.size();
            c0 = consumed;
            load(n, c, 5, 1'b0);
            verify("gaps", base, n);
            check("gaps_bytes", 32'(consumed - c0), 32'(2 * n + 2));
            check("gaps_done", 32'(done), 32'(!bad));
            check("gaps_err", 32'(err), 32'(bad));
            check("gaps_count", 32'(wcount), 32'(n));
        end

        words[0] = 16'hBEEF;
        words[1] = 16'h1357;
        base = wq.size();
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(words[0][15:8], 0);
        send_byte(words[0][7:0], 0);
        send_byte(words[1][15:8], 0);
        repeat (19) tick();
        check("tmo_early_err", 32'(err), 32'd0);
        check("tmo_early_busy", 32'(busy), 32'd1);
        tick();
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_hold", 32'(hold), 32'd1);
        check("tmo_count", 32'(wcount), 32'd1);
        repeat (5) tick();
        verify("tmo", base, 1);

        for (int i = 0; i < 256; i++) words[i] = 16'(i);
        base = wq.size();
        load(256, image_sum(256), 0, 1'b0);
        verify("full", base, 256);
        check("full_last_addr", 32'(wq[wq.size() - 1][23:16]), 32'hFF);
        check("full_count", 32'(wcount), 32'd256);
        check("full_done", 32'(done), 32'd1);

        for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
        pulse_start();
        send_byte(8'd7, 0);
        for (int i = 0; i < 5; i++) begin
            send_byte(words[i][15:8], 0);
            send_byte(words[i][7:0], 0);
        end
        send_byte(words[5][15:8], 0);
        pulse_start();
        check("ignore_start_busy", 32'(busy), 32'd1);
        check("ignore_start_rdy", 32'(rdy), 32'd1);
        check("ignore_start_count", 32'(wcount), 32'd5);
        rst_n = 1'b0;
        tick();
        check_idle("midreset");
        rst_n = 1'b1;
        tick();
        set_basic();
        base = wq.size();
        load(3, image_sum(3), 2, 1'b0);
        verify("fresh", base, 3);
        check("fresh_done", 32'(done), 32'd1);
        check("fresh_count", 32'(wcount), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
